// File: rtl/alu_pkg.sv
// Shared ALU encodings: func codes, flag codes and the multiply/divide FSM states.
// The flag codes match the single-cycle ALU so the flag register sees one encoding.
package alu_pkg;
  localparam logic [5:0] FUNC_DIV = 6'b000001;
  localparam logic [5:0] FUNC_MUL = 6'b000010;

  localparam logic [2:0] FLAG_NONE      = 3'b000;
  localparam logic [2:0] FLAG_EQUAL     = 3'b001;
  localparam logic [2:0] FLAG_EXCEPTION = 3'b010;
  localparam logic [2:0] FLAG_OVF       = 3'b011;
  localparam logic [2:0] FLAG_ABOVE     = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// Iterative datapath: 2*WIDTH accumulator, operand registers, shared add/subtract unit.
// o_hi_nxt/o_lo_nxt expose the accumulator value after the current iteration.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_op_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi_nxt,
  output logic [WIDTH-1:0] o_lo_nxt
);
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;

  // One shift-add (MUL) or restoring-divide (DIV) step; the dividend enters the remainder MSB-first.
  always_comb begin
    w_hi     = r_acc[2*WIDTH-1:WIDTH];
    w_lo     = r_acc[WIDTH-1:0];
    w_add    = {1'b0, w_hi} + {1'b0, r_opa};
    w_trial  = {w_hi, r_opa[WIDTH-1]} - {1'b0, r_opb};
    w_sum    = {1'b0, w_hi};
    o_hi_nxt = w_hi;
    o_lo_nxt = w_lo;
    if (i_op_div) begin
      if (w_trial[WIDTH]) begin
        o_hi_nxt = {w_hi[WIDTH-2:0], r_opa[WIDTH-1]};
        o_lo_nxt = {w_lo[WIDTH-2:0], 1'b0};
      end else begin
        o_hi_nxt = w_trial[WIDTH-1:0];
        o_lo_nxt = {w_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      if (r_opb[0]) begin
        w_sum = w_add;
      end else begin
        w_sum = {1'b0, w_hi};
      end
      {o_hi_nxt, o_lo_nxt} = {w_sum, w_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= {(2*WIDTH){1'b0}};
      r_opa <= {WIDTH{1'b0}};
      r_opb <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_acc <= {(2*WIDTH){1'b0}};
      r_opa <= i_a;
      r_opb <= i_b;
    end else if (i_step) begin
      r_acc <= {o_hi_nxt, o_lo_nxt};
      if (i_op_div) begin
        r_opa <= {r_opa[WIDTH-2:0], 1'b0};
      end else begin
        r_opb <= {1'b0, r_opb[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV unit for EX: FSM, iteration counter, flush handling and result registers.
// Divide-by-zero bypasses the datapath and completes in a single cycle.
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [2:0]       flag
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op_div;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_remainder;
  logic [2:0]       r_flag;
  logic             w_div0;
  logic             w_last;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  assign w_div0 = op_div & (data_b == {WIDTH{1'b0}});
  assign w_last = (r_cnt == LAST_CNT);

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_op_div (r_op_div),
    .i_a      (data_a),
    .i_b      (data_b),
    .o_hi_nxt (w_hi_nxt),
    .o_lo_nxt (w_lo_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush wins over completion of the final iteration.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && w_div0) begin
          w_state_nxt = ST_DONE;
        end else if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (r_state == ST_RUN);
    done   = (r_state == ST_DONE);
    w_load = (r_state == ST_IDLE) & start & ~w_div0;
    w_step = (r_state == ST_RUN);
    stall  = w_load | w_step;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_op_div <= 1'b0;
    end else if (w_load) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_op_div <= op_div;
    end else if (w_step) begin
      r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Results change only on entry to DONE; a flushed operation leaves them untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_result    <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_flag      <= FLAG_NONE;
    end else if ((r_state == ST_IDLE) && start && w_div0) begin
      r_result    <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_flag      <= FLAG_EXCEPTION;
    end else if ((r_state == ST_RUN) && w_last && !flush) begin
      r_result <= w_lo_nxt;
      if (r_op_div) begin
        r_remainder <= w_hi_nxt;
        r_flag      <= FLAG_NONE;
      end else begin
        r_remainder <= {WIDTH{1'b0}};
        r_flag      <= (w_hi_nxt != {WIDTH{1'b0}}) ? FLAG_OVF : FLAG_NONE;
      end
    end
  end

  assign result    = r_result;
  assign remainder = r_remainder;
  assign flag      = r_flag;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver pushes expected results from an arithmetic
// model, and a negedge monitor pops and compares whenever done is presented.
module tb_muldiv_sequencer;
  localparam int W = 32;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic [2:0]  flg;
    int          edge_n;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic [31:0] data_a = 32'd0;
  logic [31:0] data_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] result, remainder;
  logic [2:0]  flag;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t last_exp;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op_div(op_div),
    .data_a(data_a), .data_b(data_b), .flush(flush), .busy(busy),
    .stall(stall), .done(done), .result(result), .remainder(remainder), .flag(flag)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.edge_n = 0;
    if (op) begin
      if (b == 32'd0) begin
        e.res = 32'd0; e.rem = 32'd0; e.flg = 3'b010;
      end else begin
        e.res = a / b; e.rem = a % b; e.flg = 3'b000;
      end
    end else begin
      p = {32'd0, a} * {32'd0, b};
      e.res = p[31:0];
      e.rem = 32'd0;
      e.flg = (p[63:32] != 32'd0) ? 3'b011 : 3'b000;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, including its edge.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("remainder", 64'(remainder), 64'(e.rem));
        chk("flag", 64'(flag), 64'(e.flg));
        chk("done_edge", 64'(cyc), 64'(e.edge_n));
      end
    end
  end

  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input int poke_at);
    logic z;
    bit   got;
    bit   flushed;
    exp_t e;
    z = op && (b == 32'd0);
    got = 1'b0;
    flushed = 1'b0;
    @(negedge clock);
    start = 1'b1; op_div = op; data_a = a; data_b = b;
    #1;
    chk("stall_request", 64'(stall), 64'(!z));
    if (flush_at < 0) begin
      e = model(op, a, b);
      e.edge_n = cyc + 1 + (z ? 0 : W);
      sb.push_back(e);
      last_exp = e;
    end
    @(negedge clock);
    start = 1'b0; data_a = $urandom; data_b = $urandom; op_div = $urandom_range(0, 1);
    for (int i = 0; i < 40 && !got && !flushed; i++) begin
      if (done) begin
        got = 1'b1;
        chk("stall_in_done", 64'(stall), 64'(0));
      end else begin
        chk("busy_run", 64'(busy), 64'(1));
        chk("stall_run", 64'(stall), 64'(1));
        start = (i == poke_at);
        if (i == flush_at) begin
          flush = 1'b1;
          @(negedge clock);
          flush = 1'b0;
          chk("flush_busy", 64'(busy), 64'(0));
          chk("flush_done", 64'(done), 64'(0));
          chk("flush_hold_result", 64'(result), 64'(last_exp.res));
          chk("flush_hold_flag", 64'(flag), 64'(last_exp.flg));
          flushed = 1'b1;
        end else begin
          @(negedge clock);
        end
      end
    end
    start = 1'b0;
    if (!got && !flushed) chk("done_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    last_exp = model(1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_remainder", 64'(remainder), 64'(0));
    chk("rst_flag", 64'(flag), 64'(0));
    reset = 1'b0;

    do_op(1'b0, 32'd7, 32'd6, -1, -1);
    do_op(1'b0, 32'h0001_0000, 32'h0001_0000, -1, -1);
    do_op(1'b1, 32'd100, 32'd7, -1, -1);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd0, -1, -1);
    do_op(1'b1, 32'hFFFF_FFFF, 32'd1, -1, -1);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    do_op(1'b0, 32'd123, 32'd456, 10, -1);
    repeat (3) @(negedge clock);
    do_op(1'b0, 32'd5, 32'd3, -1, -1);
    do_op(1'b1, 32'd1000, 32'd33, -1, 5);

    for (int n = 0; n < 24; n++) begin
      logic        op;
      logic [31:0] a, b;
      op = $urandom_range(0, 1);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 65535));
      do_op(op, a, b, -1, -1);
    end

    do_op(1'b0, 32'd9, 32'd9, -1, -1);
    @(negedge clock);
    start = 1'b1; op_div = 1'b0; data_a = 32'd77; data_b = 32'd88;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_stall", 64'(stall), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_result", 64'(result), 64'(0));
    chk("arst_remainder", 64'(remainder), 64'(0));
    chk("arst_flag", 64'(flag), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    chk("post_reset_idle", 64'(busy), 64'(0));
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
